// File: rtl/addr_ring_decoder.sv
// addr_ring_decoder: 4-bit window address to one-hot ring, with load/rotate run FSM (optional RING_ONEHOT_CHECK_EN)
module addr_ring_decoder #(
  parameter int N  = 15,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic          start,
  input  logic [AW-1:0] len,
  input  logic          stall,
  output logic [N-1:0]  ring_out,
  output logic [AW-1:0] addr_out,
  output logic          busy,
  output logic          done,
  output logic          wrap,
  output logic          load_err,
  output logic          onehot_err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  state_t state, state_nx;
  logic [AW-1:0] cnt;
  logic bad_load, load_ok, go, step, ring_bad;
  function automatic logic [N-1:0] decode(input logic [AW-1:0] a);
    return (a == '0) ? N'(1) << (N - 1) : N'(1) << (a - 1'b1);
  endfunction
`ifdef RING_ONEHOT_CHECK_EN
  assign ring_bad = !$onehot(ring_out);
  // Sticky corruption flag, cleared only by reset
  always_ff @(posedge clk or posedge rst)
    if (rst) onehot_err <= 1'b0;
    else if (ring_bad) onehot_err <= 1'b1;
`else
  assign ring_bad   = 1'b0;
  assign onehot_err = 1'b0;
`endif
  assign bad_load = load && load_addr > LAST;
  assign load_ok  = state == IDLE && load && !bad_load;
  assign go       = state == IDLE && start && !bad_load;
  assign step     = state == RUN && !stall;
  // Next-state: an invalid load drops a same-cycle start; a corrupt ring forces IDLE
  always_comb begin
    state_nx = state;
    if (ring_bad) state_nx = IDLE;
    else if (state == IDLE) state_nx = go ? (len == '0 ? DONE : RUN) : IDLE;
    else if (state == RUN) state_nx = (step && cnt == AW'(1)) ? DONE : RUN;
    else state_nx = IDLE;
  end
  // Ring, address, step count and registered status pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      ring_out <= N'(1) << (N - 1);
      addr_out <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nx;
      busy     <= state_nx == RUN;
      done     <= state_nx == DONE && !ring_bad;
      wrap     <= step && !ring_bad && addr_out == LAST;
      load_err <= state == IDLE && bad_load && !ring_bad;
      if (ring_bad) begin
        ring_out <= decode('0);
        addr_out <= '0;
        cnt      <= '0;
      end else if (load_ok || step) begin
        ring_out <= load_ok ? decode(load_addr) : {ring_out[N-2:0], ring_out[N-1]};
        addr_out <= load_ok ? load_addr : (addr_out == LAST ? '0 : addr_out + 1'b1);
      end
      if (!ring_bad && go) cnt <= len;
      else if (!ring_bad && step) cnt <= cnt - 1'b1;
    end
endmodule

// File: tb/tb_addr_ring_decoder.sv
// tb_addr_ring_decoder: directed self-checking bench for addr_ring_decoder
module tb_addr_ring_decoder;
  logic        clk = 0, rst = 1, load = 0, start = 0, stall = 0;
  logic [3:0]  load_addr = 0, len = 0;
  logic [14:0] ring_out;
  logic [3:0]  addr_out;
  logic        busy, done, wrap, load_err, onehot_err;
  int tests = 0, fails = 0;

  addr_ring_decoder dut (
    .clk(clk), .rst(rst), .load(load), .load_addr(load_addr), .start(start),
    .len(len), .stall(stall), .ring_out(ring_out), .addr_out(addr_out),
    .busy(busy), .done(done), .wrap(wrap), .load_err(load_err), .onehot_err(onehot_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    tick();
    tests++;
    if ({ring_out, addr_out, busy, done, wrap, load_err, onehot_err} !== {15'h4000, 4'd0, 5'b0}) begin
      fails++;
      $display("FAIL reset: ring=%h addr=%0d flags=%b, expected ring=4000 addr=0 flags=00000",
               ring_out, addr_out, {busy, done, wrap, load_err, onehot_err});
    end
  endtask

  task automatic test_load();
    load = 1; load_addr = 5;
    tick();
    load = 0;
    tests++;
    if ({ring_out, addr_out, load_err} !== {15'h0010, 4'd5, 1'b0}) begin
      fails++;
      $display("FAIL load5: ring=%h addr=%0d err=%b, expected 0010 5 0", ring_out, addr_out, load_err);
    end
    load = 1; load_addr = 15; start = 1; len = 2;
    tick();
    load = 0; start = 0;
    tests++;
    if ({ring_out, addr_out, load_err, busy, done} !== {15'h0010, 4'd5, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL load15: ring=%h addr=%0d err=%b busy=%b done=%b, expected 0010 5 1 0 0",
               ring_out, addr_out, load_err, busy, done);
    end
    tick();
    tests++;
    if ({load_err, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL load_err_pulse: err/busy/done=%b, expected 000", {load_err, busy, done});
    end
  endtask

  task automatic test_wrap_run();
    logic [3:0]  ea [4] = '{4'd13, 4'd14, 4'd0, 4'd1};
    logic [14:0] er [4] = '{15'h1000, 15'h2000, 15'h4000, 15'h0001};
    logic [2:0]  ef [4] = '{3'b100, 3'b100, 3'b101, 3'b010};
    load = 1; load_addr = 13; start = 1; len = 3;
    for (int i = 0; i < 4; i++) begin
      tick();
      load = 0; start = 0;
      tests++;
      if ({addr_out, ring_out, busy, done, wrap} !== {ea[i], er[i], ef[i]}) begin
        fails++;
        $display("FAIL wrap_run[%0d]: addr=%0d ring=%h busy/done/wrap=%b, expected %0d %h %b",
                 i, addr_out, ring_out, {busy, done, wrap}, ea[i], er[i], ef[i]);
      end
    end
    tick();
    tests++;
    if ({busy, done, wrap} !== 3'b000) begin
      fails++;
      $display("FAIL wrap_run_end: busy/done/wrap=%b, expected 000", {busy, done, wrap});
    end
  endtask

  task automatic test_len0();
    start = 1; len = 0;
    tick();
    start = 0;
    tests++;
    if ({ring_out, addr_out, busy, done} !== {15'h0001, 4'd1, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL len0: ring=%h addr=%0d busy=%b done=%b, expected 0001 1 0 1", ring_out, addr_out, busy, done);
    end
    tick();
    tests++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("FAIL len0_end: busy/done=%b, expected 00", {busy, done});
    end
  endtask

  task automatic test_stall();
    logic [3:0] ea [7] = '{4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd5, 4'd6};
    logic [1:0] eb [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    load = 1; load_addr = 2; start = 1; len = 4;
    for (int i = 0; i < 7; i++) begin
      tick();
      stall = (i == 1 || i == 2);
      load  = (i == 1 || i == 2);
      start = (i == 1 || i == 2);
      load_addr = 7; len = 1;
      tests++;
      if ({addr_out, busy, done} !== {ea[i], eb[i]}) begin
        fails++;
        $display("FAIL stall[%0d]: addr=%0d busy/done=%b, expected %0d %b", i, addr_out, {busy, done}, ea[i], eb[i]);
      end
    end
    tests++;
    if (ring_out !== 15'h0020) begin
      fails++;
      $display("FAIL stall_ring: ring=%h, expected 0020", ring_out);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_done = 0;
    start = 1; len = 5;
    tick();
    start = 0;
    tick();
    #2 rst = 1;
    #1;
    tests++;
    if ({ring_out, addr_out, busy, done, wrap, load_err} !== {15'h4000, 4'd0, 4'b0}) begin
      fails++;
      $display("FAIL reset_mid: ring=%h addr=%0d flags=%b, expected 4000 0 0000",
               ring_out, addr_out, {busy, done, wrap, load_err});
    end
    tick();
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      saw_done |= done | busy;
    end
    tests++;
    if (saw_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_nodone: busy/done seen=%b, expected 0", saw_done);
    end
  endtask

`ifdef RING_ONEHOT_CHECK_EN
  task automatic test_onehot();
    load = 1; load_addr = 4;
    tick();
    load = 0;
    force dut.ring_out = 15'h0003;
    #1;
    release dut.ring_out;
    tick();
    tests++;
    if ({onehot_err, ring_out, addr_out, done} !== {1'b1, 15'h4000, 4'd0, 1'b0}) begin
      fails++;
      $display("FAIL onehot: err=%b ring=%h addr=%0d done=%b, expected 1 4000 0 0", onehot_err, ring_out, addr_out, done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_wrap_run();
    test_len0();
    test_stall();
    test_reset_mid();
`ifdef RING_ONEHOT_CHECK_EN
    test_onehot();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
